partition_buffers: RTL and testbench
====================================

Name: partition_buffers

Overview:
- Parametrised successor to the median pipeline's pivot-partition fill stage.
- Streams a window of pixels, classifies each against a latched pivot, and stores lower/larger pixels in internal register buffers.
- Reports partition sizes and min/max values.
- Drains a selected partition as a FIFO-style stream for the next quickselect iteration.

Parameters:
- DATA_W, 8, pixel width in bits
- BUFF_SIZE, 32, max pixels per window (buffer depth per partition)
- SIZE_W, $clog2(BUFF_SIZE)+1, width of size/count fields

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pivot  in  DATA_W  pivot value, latched with first accepted pixel of a window
- in_px  in  DATA_W  input pixel
- in_px_empty  in  1  input source empty
- in_px_rd  out  1  read strobe; pixel accepted when in_px_rd & ~in_px_empty
- in_buff_size  in  SIZE_W  window length, latched with first accepted pixel
- lower_size, equal_size, larger_size  out  SIZE_W  partition counts
- min_lower, max_lower, min_larger, max_larger  out  DATA_W  partition extrema
- fill_done  out  1  window complete, partitions stable
- drain_start  in  1  drain/restart command, sampled only while fill_done=1
- drain_sel  in  2  0=lower, 1=larger, 2/3=discard and restart
- out_px  out  DATA_W  drained pixel
- out_px_empty  out  1  no drained pixel available
- out_px_rd  in  1  pop drained pixel

Behaviour:
- Clock and reset: one clock clk; rst_n is asynchronous, active-low.
- Reset values:
  - state=FILL; all sizes and counts 0.
  - min_* = all-ones; max_* = 0.
  - fill_done=0; out_px_empty=1; out_px=0; in_px_rd=1.
- FSM states: FILL, DONE, DRAIN.
- FILL:
  - in_px_rd=1.
  - On accept with count==0: latch pivot and in_buff_size. A latched size of 0 or >BUFF_SIZE clamps to BUFF_SIZE. The first pixel itself is classified against the live pivot.
  - Each accepted pixel: in_px<pivot writes lower_buf[lower_size] and increments lower_size. == increments equal_size only (value is implicit). > writes larger_buf[larger_size] and increments larger_size.
  - Extrema update in the same cycle, registered.
  - When the accepted pixel makes count equal the latched size, go to DONE next cycle.
- DONE:
  - in_px_rd=0; fill_done=1; sizes and extrema held.
  - drain_start with drain_sel 0 or 1 enters DRAIN with read index 0.
  - drain_start with drain_sel 2/3 clears sizes, counts and extrema, then returns to FILL.
  - drain_start outside DONE is ignored.
- DRAIN:
  - fill_done=0; in_px_rd=0.
  - out_px = selected_buf[rd_idx] (combinational from registers).
  - out_px_empty = (rd_idx == selected size).
  - First element is visible the cycle after drain_start.
  - out_px_rd while out_px_empty=0 increments rd_idx; out_px_rd while empty is ignored.
  - When rd_idx reaches the size: clear everything and return to FILL on the following cycle.
  - Draining a size-0 partition returns to FILL one cycle after drain_start, with out_px_empty=1 throughout.
- Sizes remain readable during DRAIN and clear only on return to FILL.
- Reset mid-operation aborts any window or drain; buffer contents are don't-care after reset.
- No wrap-around: count never exceeds the latched size, so the buffers cannot overflow.

Optional Feature:
- Macro: PARTITION_MINMAX_EN.
- Defined: the min/max trackers are built and behave as described above.
- Undefined: no trackers are built; min_* tied to all-ones and max_* tied to 0 constantly.

Test Plan:
- Basic fill and drain lower:
  - Stimulus: in_buff_size=5, pivot=100, pixels 50,100,200,30,150.
  - Response: lower_size=2, equal_size=1, larger_size=2; min_lower=30, max_lower=50, min_larger=150, max_larger=200; fill_done=1 one cycle after the 5th accept.
  - Then drain_sel=0 pops 50 then 30, and the block returns to FILL.
- Input stalls:
  - Stimulus: in_px_empty toggles every other cycle during a window of 4.
  - Response: only non-empty cycles are counted; fill_done asserts after the 4th real pixel.
- Discard:
  - Stimulus: in DONE, drain_start with drain_sel=2.
  - Response: all sizes 0, min_*=255, max_*=0, in_px_rd=1 on the next cycle.
- Empty partition drain:
  - Stimulus: all pixels > pivot, then drain_sel=0.
  - Response: out_px_empty stays 1 and the block returns to FILL one cycle after drain_start.
- Size clamp and full depth:
  - Stimulus: in_buff_size=0, 32 pixels all < pivot.
  - Response: lower_size=32; drain returns all 32 in arrival order.
- Reset mid-drain:
  - Stimulus: assert rst_n=0 after 3 pops.
  - Response: immediate return to reset values; the next window fills correctly.

Source files
------------

// File: rtl/partition_buffers.sv
// ---------------------------------------------------------------------------
// partition_buffers
//
// Pivot-partition fill stage for a quickselect median pipeline.
// A window of pixels is streamed in. Each pixel is compared against a pivot
// that is latched with the first pixel of the window. Pixels below the pivot
// go into the lower buffer and pixels above it go into the larger buffer.
// Pixels equal to the pivot are only counted. When the window is complete,
// one partition can be drained as a FIFO-style stream, or the window can be
// discarded.
//
// Optional feature:
//   PARTITION_MINMAX_EN - when defined, min/max trackers are built for both
//                         partitions. When undefined, min_* is tied to
//                         all-ones and max_* is tied to zero.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   pivot               pivot value, latched with the first accepted pixel
//   in_px, in_px_empty  input pixel stream; in_px_rd is the read strobe
//   in_buff_size        window length, latched with the first accepted pixel
//                       (0 or >BUFF_SIZE selects BUFF_SIZE)
//   lower/equal/larger_size   partition counts
//   min/max_lower/larger      partition extrema
//   fill_done           window complete, partitions stable
//   drain_start, drain_sel    drain command (0=lower, 1=larger, 2/3=discard)
//   out_px, out_px_empty, out_px_rd   drained pixel stream
// ---------------------------------------------------------------------------
module partition_buffers #(
    parameter int DATA_W    = 8,
    parameter int BUFF_SIZE = 32,
    parameter int SIZE_W    = $clog2(BUFF_SIZE) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pivot,
    input  logic [DATA_W-1:0] in_px,
    input  logic              in_px_empty,
    output logic              in_px_rd,
    input  logic [SIZE_W-1:0] in_buff_size,
    output logic [SIZE_W-1:0] lower_size,
    output logic [SIZE_W-1:0] equal_size,
    output logic [SIZE_W-1:0] larger_size,
    output logic [DATA_W-1:0] min_lower,
    output logic [DATA_W-1:0] max_lower,
    output logic [DATA_W-1:0] min_larger,
    output logic [DATA_W-1:0] max_larger,
    output logic              fill_done,
    input  logic              drain_start,
    input  logic [1:0]        drain_sel,
    output logic [DATA_W-1:0] out_px,
    output logic              out_px_empty,
    input  logic              out_px_rd
);

    localparam int IDX_W = (BUFF_SIZE > 1) ? $clog2(BUFF_SIZE) : 1;
    localparam logic [SIZE_W-1:0] FULL_SIZE = SIZE_W'(BUFF_SIZE);
    localparam logic [DATA_W-1:0] ALL_ONES  = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ALL_ZEROS = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DONE  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    logic [SIZE_W-1:0] count_r;
    logic [SIZE_W-1:0] lat_size_r;
    logic [DATA_W-1:0] lat_pivot_r;
    logic [SIZE_W-1:0] lower_size_r;
    logic [SIZE_W-1:0] equal_size_r;
    logic [SIZE_W-1:0] larger_size_r;
    logic [SIZE_W-1:0] rd_idx_r;
    logic              sel_larger_r;
    logic              in_px_rd_r;
    logic              fill_done_r;

    logic [DATA_W-1:0] lower_buf_r  [BUFF_SIZE];
    logic [DATA_W-1:0] larger_buf_r [BUFF_SIZE];

    logic              accept_s;
    logic              first_s;
    logic [SIZE_W-1:0] win_size_s;
    logic [DATA_W-1:0] cur_pivot_s;
    logic              is_lower_s;
    logic              is_larger_s;
    logic              last_s;
    logic [SIZE_W-1:0] sel_size_s;
    logic              empty_s;
    logic              pop_s;
    logic              clear_s;
    logic [DATA_W-1:0] out_px_s;

    // A size of zero or beyond the buffer depth means "use the full depth".
    function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] req);
        logic [SIZE_W-1:0] res;
        if ((req == {SIZE_W{1'b0}}) || (req > FULL_SIZE)) begin
            res = FULL_SIZE;
        end else begin
            res = req;
        end
        return res;
    endfunction

    // The first pixel of a window is judged against the live pivot/size,
    // because the latched copies are only written on that same edge.
    assign accept_s    = in_px_rd_r & ~in_px_empty;
    assign first_s     = (count_r == {SIZE_W{1'b0}});
    assign win_size_s  = first_s ? clamp_size(in_buff_size) : lat_size_r;
    assign cur_pivot_s = first_s ? pivot : lat_pivot_r;
    assign is_lower_s  = (in_px < cur_pivot_s);
    assign is_larger_s = (in_px > cur_pivot_s);
    assign last_s      = ((count_r + SIZE_W'(1)) == win_size_s);

    assign sel_size_s  = sel_larger_r ? larger_size_r : lower_size_r;
    assign empty_s     = (rd_idx_r == sel_size_s);
    assign pop_s       = (state_r == DRAIN) & out_px_rd & ~empty_s;
    // Leaving a window (discard, or drain ran dry) wipes all window state.
    assign clear_s     = ((state_r == DONE) & drain_start & drain_sel[1]) |
                         ((state_r == DRAIN) & empty_s);

    // Drained pixel selection straight from the buffer registers.
    always_comb begin
        out_px_s = ALL_ZEROS;
        if ((state_r == DRAIN) && !empty_s) begin
            if (sel_larger_r) begin
                out_px_s = larger_buf_r[rd_idx_r[IDX_W-1:0]];
            end else begin
                out_px_s = lower_buf_r[rd_idx_r[IDX_W-1:0]];
            end
        end else begin
            out_px_s = ALL_ZEROS;
        end
    end

    assign out_px       = out_px_s;
    assign out_px_empty = (state_r == DRAIN) ? empty_s : 1'b1;
    assign in_px_rd     = in_px_rd_r;
    assign fill_done    = fill_done_r;
    assign lower_size   = lower_size_r;
    assign equal_size   = equal_size_r;
    assign larger_size  = larger_size_r;

    // Control FSM: window fill, hold, and drain sequencing with counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= FILL;
            count_r       <= {SIZE_W{1'b0}};
            lat_size_r    <= {SIZE_W{1'b0}};
            lat_pivot_r   <= ALL_ZEROS;
            lower_size_r  <= {SIZE_W{1'b0}};
            equal_size_r  <= {SIZE_W{1'b0}};
            larger_size_r <= {SIZE_W{1'b0}};
            rd_idx_r      <= {SIZE_W{1'b0}};
            sel_larger_r  <= 1'b0;
            in_px_rd_r    <= 1'b1;
            fill_done_r   <= 1'b0;
        end else begin
            case (state_r)
                FILL: begin
                    if (accept_s) begin
                        if (first_s) begin
                            lat_pivot_r <= pivot;
                            lat_size_r  <= win_size_s;
                        end
                        count_r <= count_r + SIZE_W'(1);
                        if (is_lower_s) begin
                            lower_size_r <= lower_size_r + SIZE_W'(1);
                        end else if (is_larger_s) begin
                            larger_size_r <= larger_size_r + SIZE_W'(1);
                        end else begin
                            equal_size_r <= equal_size_r + SIZE_W'(1);
                        end
                        if (last_s) begin
                            state_r     <= DONE;
                            in_px_rd_r  <= 1'b0;
                            fill_done_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (drain_start) begin
                        fill_done_r <= 1'b0;
                        rd_idx_r    <= {SIZE_W{1'b0}};
                        if (drain_sel[1]) begin
                            state_r       <= FILL;
                            in_px_rd_r    <= 1'b1;
                            count_r       <= {SIZE_W{1'b0}};
                            lower_size_r  <= {SIZE_W{1'b0}};
                            equal_size_r  <= {SIZE_W{1'b0}};
                            larger_size_r <= {SIZE_W{1'b0}};
                        end else begin
                            state_r      <= DRAIN;
                            sel_larger_r <= drain_sel[0];
                        end
                    end
                end
                DRAIN: begin
                    if (empty_s) begin
                        state_r       <= FILL;
                        in_px_rd_r    <= 1'b1;
                        count_r       <= {SIZE_W{1'b0}};
                        rd_idx_r      <= {SIZE_W{1'b0}};
                        lower_size_r  <= {SIZE_W{1'b0}};
                        equal_size_r  <= {SIZE_W{1'b0}};
                        larger_size_r <= {SIZE_W{1'b0}};
                    end else if (pop_s) begin
                        rd_idx_r <= rd_idx_r + SIZE_W'(1);
                    end
                end
                default: begin
                    state_r     <= FILL;
                    in_px_rd_r  <= 1'b1;
                    fill_done_r <= 1'b0;
                    count_r     <= {SIZE_W{1'b0}};
                end
            endcase
        end
    end

    // Partition storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (accept_s && is_lower_s) begin
            lower_buf_r[lower_size_r[IDX_W-1:0]] <= in_px;
        end else if (accept_s && is_larger_s) begin
            larger_buf_r[larger_size_r[IDX_W-1:0]] <= in_px;
        end
    end

`ifdef PARTITION_MINMAX_EN
    logic [DATA_W-1:0] min_lower_r;
    logic [DATA_W-1:0] max_lower_r;
    logic [DATA_W-1:0] min_larger_r;
    logic [DATA_W-1:0] max_larger_r;

    // Running extrema of each partition, reset to the empty-set values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_lower_r  <= ALL_ONES;
            max_lower_r  <= ALL_ZEROS;
            min_larger_r <= ALL_ONES;
            max_larger_r <= ALL_ZEROS;
        end else if (clear_s) begin
            min_lower_r  <= ALL_ONES;
            max_lower_r  <= ALL_ZEROS;
            min_larger_r <= ALL_ONES;
            max_larger_r <= ALL_ZEROS;
        end else if (accept_s && is_lower_s) begin
            if (in_px < min_lower_r) begin
                min_lower_r <= in_px;
            end
            if (in_px > max_lower_r) begin
                max_lower_r <= in_px;
            end
        end else if (accept_s && is_larger_s) begin
            if (in_px < min_larger_r) begin
                min_larger_r <= in_px;
            end
            if (in_px > max_larger_r) begin
                max_larger_r <= in_px;
            end
        end
    end

    assign min_lower  = min_lower_r;
    assign max_lower  = max_lower_r;
    assign min_larger = min_larger_r;
    assign max_larger = max_larger_r;
`else
    assign min_lower  = ALL_ONES;
    assign max_lower  = ALL_ZEROS;
    assign min_larger = ALL_ONES;
    assign max_larger = ALL_ZEROS;
`endif

endmodule

// File: tb/tb_partition_buffers.sv
// ---------------------------------------------------------------------------
// tb_partition_buffers
//
// Directed testbench for partition_buffers. Drained pixels are checked by a
// scoreboard: the stimulus pushes the expected drain order into a queue, and
// a monitor pops and compares whenever the DUT pops a pixel. Status outputs
// (sizes, extrema, handshakes) are compared directly against hand-computed
// values.
// ---------------------------------------------------------------------------
module tb_partition_buffers;

    localparam int DATA_W    = 8;
    localparam int BUFF_SIZE = 32;
    localparam int SIZE_W    = 6;
`ifdef PARTITION_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] pivot;
    logic [DATA_W-1:0] in_px;
    logic              in_px_empty;
    logic              in_px_rd;
    logic [SIZE_W-1:0] in_buff_size;
    logic [SIZE_W-1:0] lower_size;
    logic [SIZE_W-1:0] equal_size;
    logic [SIZE_W-1:0] larger_size;
    logic [DATA_W-1:0] min_lower;
    logic [DATA_W-1:0] max_lower;
    logic [DATA_W-1:0] min_larger;
    logic [DATA_W-1:0] max_larger;
    logic              fill_done;
    logic              drain_start;
    logic [1:0]        drain_sel;
    logic [DATA_W-1:0] out_px;
    logic              out_px_empty;
    logic              out_px_rd;

    int vectors     = 0;
    int miscompares = 0;
    logic [DATA_W-1:0] exp_q[$];

    partition_buffers #(
        .DATA_W(DATA_W), .BUFF_SIZE(BUFF_SIZE), .SIZE_W(SIZE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pivot(pivot), .in_px(in_px),
        .in_px_empty(in_px_empty), .in_px_rd(in_px_rd),
        .in_buff_size(in_buff_size), .lower_size(lower_size),
        .equal_size(equal_size), .larger_size(larger_size),
        .min_lower(min_lower), .max_lower(max_lower),
        .min_larger(min_larger), .max_larger(max_larger),
        .fill_done(fill_done), .drain_start(drain_start),
        .drain_sel(drain_sel), .out_px(out_px),
        .out_px_empty(out_px_empty), .out_px_rd(out_px_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every DUT pop is compared with the queue head.
    always @(negedge clk) begin
        if (rst_n && !out_px_empty && out_px_rd) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL drain_pop: got %0d, required no pixel", out_px);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (out_px !== e) begin
                    miscompares++;
                    $display("FAIL drain_pop: got %0d, required %0d", out_px, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Offer one pixel and hold it until the DUT accepts it.
    task automatic push_px(input logic [DATA_W-1:0] px);
        bit ok;
        ok = 1'b0;
        in_px       = px;
        in_px_empty = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_px_rd;
            @(posedge clk);
            #1;
        end
        in_px_empty = 1'b1;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: got in_px_rd=0, required 1");
        end
    endtask

    task automatic idle_cycle();
        in_px       = 8'd7;
        in_px_empty = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic start_drain(input logic [1:0] sel);
        drain_sel   = sel;
        drain_start = 1'b1;
        @(posedge clk);
        #1;
        drain_start = 1'b0;
    endtask

    // Wait (bounded) for the block to return to FILL.
    task automatic wait_fill_rd(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = in_px_rd;
        end
        chk("return_to_fill", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        pivot        = 8'd0;
        in_px        = 8'd0;
        in_px_empty  = 1'b1;
        in_buff_size = 6'd0;
        drain_start  = 1'b0;
        drain_sel    = 2'd0;
        out_px_rd    = 1'b0;
        #12;
        // Reset values
        chk("rst_in_px_rd", in_px_rd, 1);
        chk("rst_fill_done", fill_done, 0);
        chk("rst_out_px_empty", out_px_empty, 1);
        chk("rst_out_px", out_px, 0);
        chk("rst_lower_size", lower_size, 0);
        chk("rst_larger_size", larger_size, 0);
        chk("rst_min_lower", min_lower, 255);
        chk("rst_max_larger", max_larger, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic fill; pivot and size change after the first pixel must be ignored
        pivot = 8'd100;
        in_buff_size = 6'd5;
        push_px(8'd50);
        pivot = 8'd0;
        in_buff_size = 6'd2;
        push_px(8'd100);
        push_px(8'd200);
        push_px(8'd30);
        chk("basic_fill_done_early", fill_done, 0);
        push_px(8'd150);
        @(negedge clk);
        chk("basic_fill_done", fill_done, 1);
        chk("basic_in_px_rd", in_px_rd, 0);
        chk("basic_lower_size", lower_size, 2);
        chk("basic_equal_size", equal_size, 1);
        chk("basic_larger_size", larger_size, 2);
        chk("basic_min_lower", min_lower, MM ? 32'd30 : 32'd255);
        chk("basic_max_lower", max_lower, MM ? 32'd50 : 32'd0);
        chk("basic_min_larger", min_larger, MM ? 32'd150 : 32'd255);
        chk("basic_max_larger", max_larger, MM ? 32'd200 : 32'd0);
        exp_q.push_back(8'd50);
        exp_q.push_back(8'd30);
        out_px_rd = 1'b1;
        #1;
        start_drain(2'd0);
        @(negedge clk);
        chk("drain_sizes_held", lower_size, 2);
        wait_fill_rd(20);
        chk("basic_drain_all_popped", exp_q.size(), 0);
        chk("basic_sizes_cleared", lower_size, 0);
        out_px_rd = 1'b0;
        @(posedge clk);
        #1;

        // Input stalls, window of 4
        pivot = 8'd100;
        in_buff_size = 6'd4;
        push_px(8'd1);
        idle_cycle();
        push_px(8'd100);
        idle_cycle();
        push_px(8'd200);
        idle_cycle();
        chk("stall_fill_done_early", fill_done, 0);
        push_px(8'd250);
        @(negedge clk);
        chk("stall_fill_done", fill_done, 1);
        chk("stall_lower_size", lower_size, 1);
        chk("stall_equal_size", equal_size, 1);
        chk("stall_larger_size", larger_size, 2);

        // Discard from DONE
        start_drain(2'd2);
        @(negedge clk);
        chk("discard_lower_size", lower_size, 0);
        chk("discard_larger_size", larger_size, 0);
        chk("discard_equal_size", equal_size, 0);
        chk("discard_min_larger", min_larger, 255);
        chk("discard_max_larger", max_larger, 0);
        chk("discard_in_px_rd", in_px_rd, 1);
        chk("discard_fill_done", fill_done, 0);
        @(posedge clk);
        #1;

        // Empty partition drain
        pivot = 8'd10;
        in_buff_size = 6'd2;
        push_px(8'd20);
        push_px(8'd30);
        chk("emptyp_larger_size", larger_size, 2);
        out_px_rd = 1'b1;
        start_drain(2'd0);
        @(negedge clk);
        chk("emptyp_out_empty_drain", out_px_empty, 1);
        chk("emptyp_in_px_rd_drain", in_px_rd, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("emptyp_in_px_rd_fill", in_px_rd, 1);
        chk("emptyp_out_empty_fill", out_px_empty, 1);
        chk("emptyp_larger_cleared", larger_size, 0);
        out_px_rd = 1'b0;
        @(posedge clk);
        #1;

        // Size clamp (0 -> 32) and full depth
        pivot = 8'd200;
        in_buff_size = 6'd0;
        for (int i = 0; i < 32; i++) begin
            push_px(8'(i * 5));
            exp_q.push_back(8'(i * 5));
        end
        @(negedge clk);
        chk("full_fill_done", fill_done, 1);
        chk("full_lower_size", lower_size, 32);
        chk("full_min_lower", min_lower, MM ? 32'd0 : 32'd255);
        chk("full_max_lower", max_lower, MM ? 32'd155 : 32'd0);
        out_px_rd = 1'b1;
        @(posedge clk);
        #1;
        start_drain(2'd0);
        wait_fill_rd(100);
        chk("full_drain_all_popped", exp_q.size(), 0);
        out_px_rd = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-drain after 3 pops
        pivot = 8'd100;
        in_buff_size = 6'd6;
        for (int i = 1; i <= 6; i++) begin
            push_px(8'(i * 10));
            exp_q.push_back(8'(i * 10));
        end
        start_drain(2'd0);
        out_px_rd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_px_rd = 1'b0;
        @(negedge clk);
        chk("middrain_out_px", out_px, 40);
        chk("middrain_queue_left", exp_q.size(), 3);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("rst2_in_px_rd", in_px_rd, 1);
        chk("rst2_out_px_empty", out_px_empty, 1);
        chk("rst2_lower_size", lower_size, 0);
        chk("rst2_fill_done", fill_done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pivot = 8'd20;
        in_buff_size = 6'd3;
        push_px(8'd10);
        push_px(8'd20);
        push_px(8'd30);
        @(negedge clk);
        chk("post_rst_lower", lower_size, 1);
        chk("post_rst_equal", equal_size, 1);
        chk("post_rst_larger", larger_size, 1);
        exp_q.push_back(8'd30);
        out_px_rd = 1'b1;
        @(posedge clk);
        #1;
        start_drain(2'd1);
        wait_fill_rd(20);
        chk("post_rst_drain_popped", exp_q.size(), 0);
        out_px_rd = 1'b0;

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
